// File: rtl/inst_fetcher_if.sv
// Fetch-side bus bundle: instruction memory request/response and dispatcher hand-off.
// The fetcher uses the master modport; memory and dispatcher models use slave.
interface inst_fetcher_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        disp_full;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_jump;

  modport master (
    output mem_req, mem_addr, if_valid, if_inst, if_pc, if_jump,
    input  mem_valid, mem_data, disp_full
  );

  modport slave (
    input  mem_req, mem_addr, if_valid, if_inst, if_pc, if_jump,
    output mem_valid, mem_data, disp_full
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetcher: single-outstanding fetch FSM, static/BHT next-pc prediction, circular
// instruction queue to the dispatcher. Define BHT_EN to add the 16-entry 2-bit branch history table.
//
// state  | meaning
// S_IDLE | no request outstanding; issue one when the queue has room
// S_WAIT | request outstanding; push the response and advance pc
// S_DROP | request outstanding but flushed; discard its response
module inst_fetcher #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        wrong_commit,
  input  logic [31:0] commit_pc,
  input  logic        bp_upd_valid,
  input  logic [31:0] bp_upd_pc,
  input  logic        bp_upd_taken,
  inst_fetcher_if.master bus
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          mem_req_q, if_valid_q, if_jump_q;
  logic [31:0]   mem_addr_q, if_inst_q, if_pc_q;

  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic          q_jump [QUEUE_DEPTH];

  logic          push, pop, b_taken, pred;
  logic [31:0]   j_imm, b_imm, next_pc;
  logic          unused_bp;

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_jump  = if_jump_q;

  // A flush overrides any queue movement in the same cycle.
  assign push = rdy && !wrong_commit && (state == S_WAIT) && bus.mem_valid;
  assign pop  = rdy && !wrong_commit && (count != '0) && !bus.disp_full;

  assign j_imm = {{12{bus.mem_data[31]}}, bus.mem_data[19:12], bus.mem_data[20],
                  bus.mem_data[30:21], 1'b0};
  assign b_imm = {{20{bus.mem_data[31]}}, bus.mem_data[7], bus.mem_data[30:25],
                  bus.mem_data[11:8], 1'b0};

`ifdef BHT_EN
  logic [1:0] bht [16];

  assign b_taken   = bht[pc[5:2]][1];
  assign unused_bp = ^{bp_upd_pc[31:6], bp_upd_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) bht[i] <= 2'b01;
    end else if (rdy && bp_upd_valid) begin
      if (bp_upd_taken && bht[bp_upd_pc[5:2]] != 2'b11)
        bht[bp_upd_pc[5:2]] <= bht[bp_upd_pc[5:2]] + 2'b01;
      else if (!bp_upd_taken && bht[bp_upd_pc[5:2]] != 2'b00)
        bht[bp_upd_pc[5:2]] <= bht[bp_upd_pc[5:2]] - 2'b01;
    end
  end
`else
  assign b_taken   = 1'b0;
  assign unused_bp = ^{bp_upd_valid, bp_upd_taken, bp_upd_pc};
`endif

  always_comb begin
    next_pc = pc + 32'd4;
    pred    = 1'b0;
    if (bus.mem_data[6:0] == OP_JAL) begin
      next_pc = pc + j_imm;
      pred    = 1'b1;
    end else if (bus.mem_data[6:0] == OP_BR && b_taken) begin
      next_pc = pc + b_imm;
      pred    = 1'b1;
    end
  end

  // Queue storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[tail] <= bus.mem_data;
      q_pc[tail]   <= pc;
      q_jump[tail] <= pred;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      if_jump_q  <= 1'b0;
    end else if (rdy) begin
      mem_req_q <= 1'b0;
      if (wrong_commit) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        if_valid_q <= 1'b0;
        pc         <= commit_pc;
        case (state)
          S_WAIT, S_DROP: state <= bus.mem_valid ? S_IDLE : S_DROP;
          default:        state <= S_IDLE;
        endcase
      end else begin
        if (pop) begin
          if_valid_q <= 1'b1;
          if_inst_q  <= q_inst[head];
          if_pc_q    <= q_pc[head];
          if_jump_q  <= q_jump[head];
          head       <= head + PW'(1);
        end else begin
          if_valid_q <= 1'b0;
        end
        if (push) tail <= tail + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        case (state)
          S_IDLE: begin
            if (count < CW'(QUEUE_DEPTH)) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc;
              state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.mem_valid) begin
              pc    <= next_pc;
              state <= S_IDLE;
            end
          end
          S_DROP: begin
            if (bus.mem_valid) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end else begin
      mem_req_q <= 1'b0;
    end
  end

endmodule
